inv_mix_columns_multi: RTL and testbench
========================================

// Module: inv_mix_columns_multi
// PURPOSE
//  Multi-column successor to the 16-bit inverse MixColumns stage of the cryptographic core.
//  - Accepts a full cipher state of NCOL 16-bit columns over a valid/ready handshake.
//  - Applies the inverse column transform one column per cycle through a shared column datapath.
//  - Holds the result until the downstream stage accepts it.
//  - Sits between the inverse-ShiftRows and AddRoundKey stages of the decrypt path.
// PARAMETERS
//  NCOL   4   number of 16-bit columns per state; >=1; state width SW = 16*NCOL
//  CNTW   $clog2(NCOL)+1   column counter width (derived, do not override)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    in_data/in_bypass valid
//  in_ready   out  1    block can accept a state this cycle
//  in_data    in   SW   state; column 0 = bits [SW-1:SW-16]
//  in_bypass  in   1    1 = pass state through untransformed (sampled with in_data)
//  out_valid  out  1    out_data valid
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  SW   transformed state, same column ordering as in_data
//  busy       out  1    1 while columns are being processed (BUSY state)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; out_valid=0; busy=0; out_data=0; column counter=0.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); it is combinational in out_ready.
//  - FSM:
//    - IDLE: on in_valid&in_ready, register in_data. If in_bypass=1 go to DONE, else go to BUSY with cnt=0.
//    - BUSY: each cycle replace column cnt with f(column cnt) in place, then cnt++.
//      After column NCOL-1 is written, go to DONE.
//    - DONE: out_valid=1; out_data is the state register, held stable while out_ready=0.
//      On out_ready: if in_valid, accept a new state and go straight to BUSY or DONE (back-to-back). Otherwise go to IDLE.
//  - Latency from the accepting edge to out_valid=1: NCOL cycles normally, 1 cycle on bypass.
//  - Throughput: one state per NCOL+1 cycles normally.
//  - in_valid in BUSY is ignored (in_ready=0); the upstream stage must hold its data.
//  - out_ready in IDLE/BUSY has no effect.
//  - Column function f, nibbles A,B,C,D = col[15:12],[11:8],[7:4],[3:0]:
//    - Arithmetic is GF(2^4) with x^4+x+1. m2(x) = x[3] ? ((x<<1)^4'h3) : (x<<1), truncated to 4 bits.
//    - m3(x) = m2(x)^x.
//    - out[15:12] = A ^ m3(B) ^ C ^ m2(D)
//    - out[11:8]  = m2(A) ^ B ^ m3(C) ^ D
//    - out[7:4]   = A ^ m2(B) ^ C ^ m3(D)
//    - out[3:0]   = m3(A) ^ B ^ m2(C) ^ D
//  - Counter reaches at most NCOL-1 and returns to 0 on entering DONE; there is no wrap within a state.
//  - NCOL=1: BUSY lasts exactly 1 cycle.
//  - Reset mid-operation: the partial state is discarded, all outputs return to reset values immediately, and no output handshake occurs.
// STRUCTURE
//  - Shared package crypto_pkg:
//    - NIB_W=4, COL_W=16, GF4_POLY_LOW=4'h3
//    - functions gf4_mul2/gf4_mul3
//    - FSM state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2
//  - Sub-module inv_mix_col_nib4: purely combinational 16-bit column transform f(); one instance muxed by cnt.
//  - Top level: state register, column counter, FSM, handshake logic.
// TESTING (NCOL=1 unless noted)
//  - Reset: hold rst=0 with random inputs -> out_valid=0, busy=0, out_data=0, in_ready=1.
//  - Accept 16'ha3c1 -> 1 cycle later out_valid=1, out_data=16'h1234.
//    Also check 16'h7070 -> 16'h0707, 16'hFFFF -> 16'hFFFF, 16'h0000 -> 16'h0000.
//  - NCOL=4, in_data=64'ha3c1_7070_ffff_0000 -> after 4 cycles out_data=64'h1234_0707_ffff_0000; busy=1 for exactly 4 cycles.
//  - Backpressure: hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0.
//    Then out_ready=1 with in_valid=1 -> next state accepted in the same cycle.
//  - Bypass: in_bypass=1, in_data=16'ha3c1 -> out_valid next cycle, out_data=16'ha3c1, busy never 1.
//  - NCOL=4, drop rst to 0 during BUSY at cnt=2 -> outputs reset at once.
//    After release, a fresh 16'ha3c1-based state processes correctly.

Source files
------------

// File: rtl/crypto_pkg.sv
// ---------------------------------------------------------------------------
// crypto_pkg : shared GF(2^4) helpers and FSM encoding for the MixColumns stages
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package crypto_pkg;

    localparam int          NIB_W        = 4;
    localparam int          COL_W        = 16;
    localparam logic [3:0]  GF4_POLY_LOW = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by x in GF(2^4) modulo x^4+x+1
    function automatic logic [NIB_W-1:0] gf4_mul2(input logic [NIB_W-1:0] x);
        logic [NIB_W-1:0] sh;
        sh = {x[NIB_W-2:0], 1'b0};
        return x[NIB_W-1] ? (sh ^ GF4_POLY_LOW) : sh;
    endfunction

    function automatic logic [NIB_W-1:0] gf4_mul3(input logic [NIB_W-1:0] x);
        return gf4_mul2(x) ^ x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mix_columns_multi_if.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_multi_if : state-in / state-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface inv_mix_columns_multi_if #(
    parameter int NCOL = 4
) ();
    localparam int SW = 16 * NCOL;

    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          busy;

    modport master (
        output in_valid,
        output in_data,
        output in_bypass,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_bypass,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/inv_mix_col_nib4.sv
// ---------------------------------------------------------------------------
// inv_mix_col_nib4 : combinational inverse MixColumns on one 16-bit column
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inv_mix_col_nib4
    import crypto_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);
    logic [NIB_W-1:0] a, b, c, d;

    assign a = col_i[15:12];
    assign b = col_i[11:8];
    assign c = col_i[7:4];
    assign d = col_i[3:0];

    assign col_o[15:12] = a ^ gf4_mul3(b) ^ c ^ gf4_mul2(d);
    assign col_o[11:8]  = gf4_mul2(a) ^ b ^ gf4_mul3(c) ^ d;
    assign col_o[7:4]   = a ^ gf4_mul2(b) ^ c ^ gf4_mul3(d);
    assign col_o[3:0]   = gf4_mul3(a) ^ b ^ gf4_mul2(c) ^ d;
endmodule

`default_nettype wire

// File: rtl/inv_mix_columns_multi.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_multi : multi-column inverse MixColumns, one column per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inv_mix_columns_multi
    import crypto_pkg::*;
#(
    parameter int NCOL = 4,
    parameter int CNTW = $clog2(NCOL) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_mix_columns_multi_if.slave bus
);
    localparam int SW = COL_W * NCOL;

    state_e           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [SW-1:0]    data_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             in_ready;
    logic             take;
    logic [COL_W-1:0] col_sel;
    logic [COL_W-1:0] col_d;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign take     = bus.in_valid && in_ready;

    always_comb begin
        col_sel = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (cnt_q == CNTW'(i)) begin
                col_sel = data_q[SW-1-COL_W*i -: COL_W];
            end
        end
    end

    inv_mix_col_nib4 u_col (
        .col_i (col_sel),
        .col_o (col_d)
    );

    // Single FSM: a DONE state with out_ready may take a new state in the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (take) begin
                        data_q <= bus.in_data;
                        cnt_q  <= '0;
                        if (bus.in_bypass) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q     <= ST_BUSY;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else if ((state_q == ST_DONE) && bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < NCOL; i++) begin
                        if (cnt_q == CNTW'(i)) begin
                            data_q[SW-1-COL_W*i -: COL_W] <= col_d;
                        end
                    end
                    if (cnt_q == CNTW'(NCOL - 1)) begin
                        state_q     <= ST_DONE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_inv_mix_columns_multi.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_multi : NCOL=1 and NCOL=4 instances against a GF(2^4) matrix model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inv_mix_columns_multi;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inv_mix_columns_multi_if #(.NCOL(1)) b1 ();
    inv_mix_columns_multi_if #(.NCOL(4)) b4 ();

    inv_mix_columns_multi #(.NCOL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    inv_mix_columns_multi #(.NCOL(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    int checks = 0;
    int errors = 0;

    logic [63:0] q1[$];
    logic [63:0] q4[$];
    logic        pv[2];
    logic        pr[2];
    logic [63:0] pd[2];

    // ---------------- reference model ----------------
    function automatic logic [3:0] gmul(input int k, input logic [3:0] x);
        logic [3:0] p;
        logic [3:0] a;
        logic       hi;
        p = 4'h0;
        a = x;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            hi = a[3];
            a  = {a[2:0], 1'b0};
            if (hi) a = a ^ 4'h3;
        end
        return p;
    endfunction

    function automatic logic [15:0] col_ref(input logic [15:0] c);
        int         m [4][4];
        logic [3:0] v [4];
        logic [3:0] o;
        logic [15:0] r;
        m = '{'{1, 3, 1, 2}, '{2, 1, 3, 1}, '{1, 2, 1, 3}, '{3, 1, 2, 1}};
        v[0] = c[15:12]; v[1] = c[11:8]; v[2] = c[7:4]; v[3] = c[3:0];
        r = 16'h0;
        for (int row = 0; row < 4; row++) begin
            o = 4'h0;
            for (int j = 0; j < 4; j++) o = o ^ gmul(m[row][j], v[j]);
            r = r | (16'(o) << (4 * (3 - row)));
        end
        return r;
    endfunction

    function automatic logic [63:0] state_ref(input logic [63:0] d, input int n, input logic byp);
        logic [63:0] r;
        logic [15:0] c;
        if (byp) return d;
        r = 64'h0;
        for (int k = 0; k < n; k++) begin
            c = 16'(d >> (16 * (n - 1 - k)));
            r = r | (64'(col_ref(c)) << (16 * (n - 1 - k)));
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic g_ov(input int s);   return (s == 0) ? b1.out_valid : b4.out_valid; endfunction
    function automatic logic g_busy(input int s); return (s == 0) ? b1.busy : b4.busy; endfunction
    function automatic logic g_ir(input int s);   return (s == 0) ? b1.in_ready : b4.in_ready; endfunction
    function automatic logic [63:0] g_data(input int s);
        return (s == 0) ? 64'(b1.out_data) : b4.out_data;
    endfunction

    task automatic drive(input int s, input logic v, input logic [63:0] d, input logic byp, input logic ordy);
        if (s == 0) begin
            b1.in_valid = v; b1.in_data = d[15:0]; b1.in_bypass = byp; b1.out_ready = ordy;
        end else begin
            b4.in_valid = v; b4.in_data = d;       b4.in_bypass = byp; b4.out_ready = ordy;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic mon(input int s, input logic iv, input logic ir, input logic [63:0] id, input logic ib,
                       input logic ov, input logic ordy, input logic [63:0] od, input logic bz);
        int          n;
        int          sz;
        logic [63:0] e;
        n = (s == 0) ? 1 : 4;
        if (!rst) begin
            if (s == 0) q1.delete(); else q4.delete();
            pv[s] = 1'b0; pr[s] = 1'b0; pd[s] = 64'h0;
            return;
        end
        chk("in_ready_rule", 64'(ir), 64'((!ov && !bz) || (ov && ordy)));
        if (pv[s] && !pr[s]) begin
            chk("hold_valid", 64'(ov), 64'(1));
            chk("hold_data", od, pd[s]);
        end
        if (ov && ordy) begin
            sz = (s == 0) ? q1.size() : q4.size();
            chk("output_has_input", 64'(sz > 0), 64'(1));
            if (sz > 0) begin
                e = (s == 0) ? q1.pop_front() : q4.pop_front();
                chk("model_data", od, e);
            end
        end
        if (iv && ir) begin
            if (s == 0) q1.push_back(state_ref(id, n, ib));
            else        q4.push_back(state_ref(id, n, ib));
        end
        pv[s] = ov; pr[s] = ordy; pd[s] = od;
    endtask

    always @(negedge clk) begin
        mon(0, b1.in_valid, b1.in_ready, 64'(b1.in_data), b1.in_bypass,
            b1.out_valid, b1.out_ready, 64'(b1.out_data), b1.busy);
        mon(1, b4.in_valid, b4.in_ready, b4.in_data, b4.in_bypass,
            b4.out_valid, b4.out_ready, b4.out_data, b4.busy);
    end

    // ---------------- directed transfer ----------------
    task automatic xfer(input int s, input logic [63:0] d, input logic byp, input logic [63:0] exp,
                        input int exp_lat, input int exp_busy, input string nm);
        int n, lat, bc;
        @(posedge clk); #1;
        drive(s, 1'b1, d, byp, 1'b1);
        n = 0;
        @(negedge clk);
        while (!g_ir(s) && n < 50) begin @(negedge clk); n++; end
        chk({nm, "_accept"}, 64'(n < 50), 64'(1));
        @(posedge clk); #1;
        drive(s, 1'b0, 64'h0, 1'b0, 1'b1);
        lat = 0; bc = 0;
        while (lat < 50) begin
            @(negedge clk);
            if (g_ov(s)) break;
            if (g_busy(s)) bc++;
            lat++;
        end
        chk({nm, "_edges_to_valid"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        chk({nm, "_data"}, g_data(s), exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        logic acc1, acc4;

        drive(0, 1'b0, 64'h0, 1'b0, 1'b1);
        drive(1, 1'b0, 64'h0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(0, 1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            drive(1, 1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                chk("reset_out_valid", 64'(g_ov(s)), 64'(0));
                chk("reset_busy", 64'(g_busy(s)), 64'(0));
                chk("reset_out_data", g_data(s), 64'h0);
                chk("reset_in_ready", 64'(g_ir(s)), 64'(1));
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h0, 1'b0, 1'b1);
        drive(1, 1'b0, 64'h0, 1'b0, 1'b1);
        rst = 1'b1;

        xfer(0, 64'ha3c1, 1'b0, 64'h1234, 1, 1, "c1_a3c1");
        xfer(0, 64'h7070, 1'b0, 64'h0707, 1, 1, "c1_7070");
        xfer(0, 64'hffff, 1'b0, 64'hffff, 1, 1, "c1_ffff");
        xfer(0, 64'h0000, 1'b0, 64'h0000, 1, 1, "c1_0000");
        xfer(0, 64'ha3c1, 1'b1, 64'ha3c1, 0, 0, "c1_bypass");
        xfer(1, 64'ha3c1_7070_ffff_0000, 1'b0, 64'h1234_0707_ffff_0000, 4, 4, "c4_vec");
        xfer(1, 64'h0123_4567_89ab_cdef, 1'b1, 64'h0123_4567_89ab_cdef, 0, 0, "c4_bypass");

        // backpressure then back-to-back accept on the releasing edge
        @(posedge clk); #1;
        drive(0, 1'b1, 64'h7070, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!g_ir(0) && n < 50) begin @(negedge clk); n++; end
        chk("bp_accept", 64'(n < 50), 64'(1));
        @(posedge clk); #1;
        drive(0, 1'b1, 64'ha3c1, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!g_ov(0) && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid", 64'(n < 50), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(g_ir(0)), 64'(0));
            chk("bp_data", g_data(0), 64'h0707);
            @(negedge clk);
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 64'ha3c1, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(g_ir(0)), 64'(1));
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_busy", 64'(g_busy(0)), 64'(1));
        chk("b2b_out_valid", 64'(g_ov(0)), 64'(0));
        @(negedge clk);
        chk("b2b_result_valid", 64'(g_ov(0)), 64'(1));
        chk("b2b_result_data", g_data(0), 64'h1234);

        // asynchronous reset while column 2 is next
        @(posedge clk); #1;
        drive(1, 1'b1, 64'ha3c1_7070_ffff_0000, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!g_ir(1) && n < 50) begin @(negedge clk); n++; end
        chk("rst_mid_accept", 64'(n < 50), 64'(1));
        @(posedge clk); #1;
        drive(1, 1'b0, 64'h0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 64'(g_busy(1)), 64'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(g_ov(1)), 64'(0));
        chk("rst_mid_busy", 64'(g_busy(1)), 64'(0));
        chk("rst_mid_out_data", g_data(1), 64'h0);
        chk("rst_mid_in_ready", 64'(g_ir(1)), 64'(1));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        xfer(1, 64'ha3c1_0000_a3c1_7070, 1'b0, 64'h1234_0000_1234_0707, 4, 4, "c4_after_rst");

        // randomized traffic on both instances, scoreboard does the checking
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            acc1 = b1.in_valid && b1.in_ready;
            acc4 = b4.in_valid && b4.in_ready;
            @(posedge clk); #1;
            if (acc1 || !b1.in_valid) begin
                b1.in_valid  = 1'($urandom_range(0, 1));
                b1.in_data   = 16'($urandom);
                b1.in_bypass = ($urandom_range(0, 3) == 0);
            end
            if (acc4 || !b4.in_valid) begin
                b4.in_valid  = 1'($urandom_range(0, 1));
                b4.in_data   = {$urandom, $urandom};
                b4.in_bypass = ($urandom_range(0, 3) == 0);
            end
            b1.out_ready = ($urandom_range(0, 3) != 0);
            b4.out_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        drive(0, 1'b0, 64'h0, 1'b0, 1'b1);
        drive(1, 1'b0, 64'h0, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drain_q1", 64'(q1.size()), 64'(0));
        chk("drain_q4", 64'(q4.size()), 64'(0));

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
